// File: rtl/rope_grab_detector_pkg.sv
// Shared types for the rope grab detector: FSM states, event codes, coordinate width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rope_grab_pkg;

   localparam int COORD_W = 11;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   typedef enum logic {
      EV_GRAB    = 1'b0,
      EV_RELEASE = 1'b1
   } event_t;

endpackage

// File: rtl/rope_grab_detector_accumulator.sv
// Per-frame overlap accumulator: saturating hit counter plus leftmost/topmost hit trackers.
// Latency: one cycle; a hit sampled at an edge is reflected in the outputs after that edge.
// Backpressure: none; clear and hit are sampled every cycle, a hit on a clear cycle seeds the new frame.
module overlap_accumulator
   import rope_grab_pkg::*;
#(
   parameter int CNT_W = 12
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               hit,
   input  logic [COORD_W-1:0] pixelX,
   input  logic [COORD_W-1:0] pixelY,
   output logic [CNT_W-1:0]   count,
   output logic [COORD_W-1:0] minX,
   output logic [COORD_W-1:0] minY
);

   // Count hits and track the minimum coordinates; clear restarts the frame with the current pixel.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         minX  <= '1;
         minY  <= '1;
      end else if (clear) begin
         count <= hit ? CNT_W'(1) : '0;
         minX  <= hit ? pixelX : '1;
         minY  <= hit ? pixelY : '1;
      end else if (hit) begin
         // Saturate instead of wrapping so a very large overlap never reads as small.
         if (count != '1) begin
            count <= count + CNT_W'(1);
         end
         if (pixelX < minX) begin
            minX <= pixelX;
         end
         if (pixelY < minY) begin
            minY <= pixelY;
         end
      end
   end

endmodule

// File: rtl/rope_grab_detector.sv
// Rope/player overlap detector: per-frame overlap stats, on-rope decision and grab/release events (ROPE_GRAB_HYST_EN adds release hysteresis).
// Latency: frame results and event appear the cycle after the startOfFrame pulse that closes the frame.
// Backpressure: eventReq holds until eventAck; a newer event overwrites a pending one and sets sticky eventOverrun.
module rope_grab_detector
   import rope_grab_pkg::*;
#(
   parameter int OVERLAP_THRESHOLD = 8,
   parameter int CNT_W             = 12,
   parameter int SCREEN_W          = 640,
   parameter int SCREEN_H          = 480
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               startOfFrame,
   input  logic [COORD_W-1:0] pixelX,
   input  logic [COORD_W-1:0] pixelY,
   input  logic               ropeDR,
   input  logic               playerDR,
   output logic               onRope,
   output logic [CNT_W-1:0]   overlapCount,
   output logic [COORD_W-1:0] grabX,
   output logic [COORD_W-1:0] grabY,
   output logic               eventReq,
   output logic               eventType,
   output logic               eventOverrun,
   input  logic               eventAck
);

   localparam logic [COORD_W-1:0] SCR_W = COORD_W'(SCREEN_W);
   localparam logic [COORD_W-1:0] SCR_H = COORD_W'(SCREEN_H);
`ifdef ROPE_GRAB_HYST_EN
   localparam int RELEASE_THRESHOLD = OVERLAP_THRESHOLD / 2;
`endif

   state_t               state;
   event_t               ev_type;
   logic                 hit;
   logic                 commit;
   logic                 new_on;
   logic [CNT_W-1:0]     acc_count;
   logic [COORD_W-1:0]   acc_min_x;
   logic [COORD_W-1:0]   acc_min_y;

   // Qualify overlap pixels; only pixels inside the active area of a frame being scanned count.
   always_comb begin
      hit    = ropeDR & playerDR & (pixelX < SCR_W) & (pixelY < SCR_H) & (state == SCAN);
      commit = (state == SCAN) & startOfFrame;
   end

   // Decide the on-rope level for the frame being closed.
   always_comb begin
      new_on = 1'b0;
`ifdef ROPE_GRAB_HYST_EN
      if (onRope) begin
         new_on = (int'(acc_count) >= RELEASE_THRESHOLD);
      end else begin
         new_on = (int'(acc_count) >= OVERLAP_THRESHOLD);
      end
`else
      new_on = (int'(acc_count) >= OVERLAP_THRESHOLD);
`endif
   end

   overlap_accumulator #(
      .CNT_W (CNT_W)
   ) u_acc (
      .clk    (clk),
      .reset  (reset),
      .clear  (startOfFrame),
      .hit    (hit),
      .pixelX (pixelX),
      .pixelY (pixelY),
      .count  (acc_count),
      .minX   (acc_min_x),
      .minY   (acc_min_y)
   );

   assign eventType = ev_type;

   // Frame FSM, commit registers and event handshake; a new event always beats a same-cycle ack.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         onRope       <= 1'b0;
         overlapCount <= '0;
         grabX        <= '0;
         grabY        <= '0;
         eventReq     <= 1'b0;
         ev_type      <= EV_GRAB;
         eventOverrun <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // The partial frame seen before the first boundary is discarded.
               if (startOfFrame) begin
                  state <= SCAN;
               end
            end
            SCAN: begin
               state <= SCAN;
            end
            default: begin
               state <= IDLE;
            end
         endcase

         if (commit) begin
            overlapCount <= acc_count;
            onRope       <= new_on;
            grabX        <= (acc_count != '0) ? acc_min_x : '0;
            grabY        <= (acc_count != '0) ? acc_min_y : '0;
         end

         if (commit && (new_on != onRope)) begin
            if (eventReq && !eventAck) begin
               eventOverrun <= 1'b1;
            end
            eventReq <= 1'b1;
            ev_type  <= new_on ? EV_GRAB : EV_RELEASE;
         end else if (eventReq && eventAck) begin
            eventReq <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rope_grab_detector.sv
// Directed bench: a frame-level reference model checked every cycle, plus hand-computed literals.
// Latency: n/a.
// Backpressure: n/a.
module tb_rope_grab_detector;

   localparam int BIG = 1 << 30;

   logic        clk;
   logic        reset;
   logic        startOfFrame;
   logic [10:0] pixelX;
   logic [10:0] pixelY;
   logic        ropeDR;
   logic        playerDR;
   logic        eventAck;

   logic        onRope;
   logic [11:0] overlapCount;
   logic [10:0] grabX;
   logic [10:0] grabY;
   logic        eventReq;
   logic        eventType;
   logic        eventOverrun;

   logic        onRope4;
   logic [3:0]  overlapCount4;
   logic [10:0] grabX4;
   logic [10:0] grabY4;
   logic        eventReq4;
   logic        eventType4;
   logic        eventOverrun4;

   int total;
   int bad;
   bit chk_en;

   // reference model state
   bit m_scan;
   int m_hits;
   int m_minx;
   int m_miny;
   bit e_on;
   int e_cnt;
   int e_cnt4;
   int e_gx;
   int e_gy;
   bit e_req;
   bit e_type;
   bit e_ovr;

   rope_grab_detector dut (
      .clk          (clk),
      .reset        (reset),
      .startOfFrame (startOfFrame),
      .pixelX       (pixelX),
      .pixelY       (pixelY),
      .ropeDR       (ropeDR),
      .playerDR     (playerDR),
      .onRope       (onRope),
      .overlapCount (overlapCount),
      .grabX        (grabX),
      .grabY        (grabY),
      .eventReq     (eventReq),
      .eventType    (eventType),
      .eventOverrun (eventOverrun),
      .eventAck     (eventAck)
   );

   rope_grab_detector #(.CNT_W(4)) dut4 (
      .clk          (clk),
      .reset        (reset),
      .startOfFrame (startOfFrame),
      .pixelX       (pixelX),
      .pixelY       (pixelY),
      .ropeDR       (ropeDR),
      .playerDR     (playerDR),
      .onRope       (onRope4),
      .overlapCount (overlapCount4),
      .grabX        (grabX4),
      .grabY        (grabY4),
      .eventReq     (eventReq4),
      .eventType    (eventType4),
      .eventOverrun (eventOverrun4),
      .eventAck     (eventAck)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level model: counts hits per frame, publishes at a boundary, derives events from level changes.
   always @(posedge clk) begin
      bit h;
      bit newon;
      h = ropeDR && playerDR && (int'(pixelX) < 640) && (int'(pixelY) < 480);
      if (reset) begin
         m_scan = 0; m_hits = 0; m_minx = BIG; m_miny = BIG;
         e_on = 0; e_cnt = 0; e_cnt4 = 0; e_gx = 0; e_gy = 0;
         e_req = 0; e_type = 0; e_ovr = 0;
      end else if (m_scan && startOfFrame) begin
`ifdef ROPE_GRAB_HYST_EN
         newon = e_on ? (m_hits >= 4) : (m_hits >= 8);
`else
         newon = (m_hits >= 8);
`endif
         if (newon != e_on) begin
            if (e_req && !eventAck) e_ovr = 1;
            e_req  = 1;
            e_type = newon ? 1'b0 : 1'b1;
         end else if (e_req && eventAck) begin
            e_req = 0;
         end
         e_on   = newon;
         e_cnt  = (m_hits > 4095) ? 4095 : m_hits;
         e_cnt4 = (m_hits > 15) ? 15 : m_hits;
         e_gx   = (m_hits > 0) ? m_minx : 0;
         e_gy   = (m_hits > 0) ? m_miny : 0;
         m_hits = h ? 1 : 0;
         m_minx = h ? int'(pixelX) : BIG;
         m_miny = h ? int'(pixelY) : BIG;
      end else begin
         if (e_req && eventAck) e_req = 0;
         if (m_scan && h) begin
            m_hits++;
            if (int'(pixelX) < m_minx) m_minx = int'(pixelX);
            if (int'(pixelY) < m_miny) m_miny = int'(pixelY);
         end
         if (!m_scan && startOfFrame) begin
            m_scan = 1; m_hits = 0; m_minx = BIG; m_miny = BIG;
         end
      end
   end

   // Compare both DUTs against the model on every falling edge once reset has been applied.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_onRope",       int'(onRope),        int'(e_on));
         chk("cyc_overlapCount", int'(overlapCount),  e_cnt);
         chk("cyc_grabX",        int'(grabX),         e_gx);
         chk("cyc_grabY",        int'(grabY),         e_gy);
         chk("cyc_eventReq",     int'(eventReq),      int'(e_req));
         if (e_req) chk("cyc_eventType", int'(eventType), int'(e_type));
         chk("cyc_eventOverrun", int'(eventOverrun),  int'(e_ovr));
         chk("cyc_overlapCount4", int'(overlapCount4), e_cnt4);
         chk("cyc_onRope4",      int'(onRope4),       int'(e_on));
      end
   end

   task automatic cyc(input bit sof, input int x, input int y, input bit r, input bit p, input bit ack);
      startOfFrame = sof;
      pixelX       = 11'(x);
      pixelY       = 11'(y);
      ropeDR       = r;
      playerDR     = p;
      eventAck     = ack;
      @(posedge clk);
      #1;
   endtask

   task automatic sof_pulse(input bit ack);
      cyc(1'b1, 1, 1, 1'b0, 1'b0, ack);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 3, 3, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic ack_cycle();
      cyc(1'b0, 3, 3, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic hits(input int n, input int x0, input int y);
      for (int i = 0; i < n; i++) cyc(1'b0, x0 + i, y, 1'b1, 1'b1, 1'b0);
   endtask

   initial begin
      total = 0; bad = 0; chk_en = 0;
      reset = 1'b1; startOfFrame = 1'b0; pixelX = '0; pixelY = '0;
      ropeDR = 1'b0; playerDR = 1'b0; eventAck = 1'b0;
      @(posedge clk); #1;
      chk_en = 1;
      cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
      chk("rst_onRope", int'(onRope), 0);
      chk("rst_overlapCount", int'(overlapCount), 0);
      chk("rst_eventReq", int'(eventReq), 0);
      reset = 1'b0;

      // reset in the middle of a frame with 5 overlaps, then two empty frames
      sof_pulse(0);
      hits(5, 50, 50);
      reset = 1'b1; idle(1); reset = 1'b0;
      sof_pulse(0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 60 + i, 60, 1'b1, 1'b0, 1'b0);
      sof_pulse(0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 60 + i, 60, 1'b0, 1'b1, 1'b0);
      sof_pulse(0);
      chk("empty_overlapCount", int'(overlapCount), 0);
      chk("empty_onRope", int'(onRope), 0);
      chk("empty_grabX", int'(grabX), 0);
      chk("empty_grabY", int'(grabY), 0);
      chk("empty_eventReq", int'(eventReq), 0);

      // 10 overlaps at X=200..209, Y=150 -> GRAB
      cyc(1'b0, 100, 150, 1'b1, 1'b0, 1'b0);
      hits(10, 200, 150);
      sof_pulse(0);
      chk("grab_overlapCount", int'(overlapCount), 10);
      chk("grab_onRope", int'(onRope), 1);
      chk("grab_grabX", int'(grabX), 200);
      chk("grab_grabY", int'(grabY), 150);
      chk("grab_eventReq", int'(eventReq), 1);
      chk("grab_eventType", int'(eventType), 0);
      idle(2);
      chk("grab_held", int'(eventReq), 1);
      ack_cycle();
      chk("grab_acked", int'(eventReq), 0);

      // 3 overlaps -> RELEASE pending; then 12 overlaps unacked -> GRAB with overrun
      hits(3, 300, 10);
      sof_pulse(0);
      chk("rel_onRope", int'(onRope), 0);
      chk("rel_eventType", int'(eventType), 1);
      chk("rel_grabX", int'(grabX), 300);
      hits(12, 20, 30);
      sof_pulse(0);
      chk("ovr_eventType", int'(eventType), 0);
      chk("ovr_eventOverrun", int'(eventOverrun), 1);
      chk("ovr_overlapCount", int'(overlapCount), 12);
      ack_cycle();

      // only out-of-area overlaps count nothing
      cyc(1'b0, 640, 10, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 10, 480, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 700, 500, 1'b1, 1'b1, 1'b0);
      sof_pulse(0);
      chk("edge_overlapCount", int'(overlapCount), 0);
      chk("edge_grabX", int'(grabX), 0);
      ack_cycle();
      cyc(1'b0, 639, 479, 1'b1, 1'b1, 1'b0);
      sof_pulse(0);
      chk("corner_overlapCount", int'(overlapCount), 1);
      chk("corner_grabX", int'(grabX), 639);
      chk("corner_grabY", int'(grabY), 479);

      // 20 overlaps: 4-bit counter saturates at 15
      hits(20, 0, 0);
      sof_pulse(0);
      chk("sat_overlapCount", int'(overlapCount), 20);
      chk("sat_overlapCount4", int'(overlapCount4), 15);
      ack_cycle();

      // back-to-back boundaries; the boundary pixel seeds the one-cycle frame
      cyc(1'b1, 5, 6, 1'b1, 1'b1, 1'b0);
      sof_pulse(0);
      chk("b2b_overlapCount", int'(overlapCount), 1);
      chk("b2b_grabX", int'(grabX), 5);
      chk("b2b_grabY", int'(grabY), 6);
      ack_cycle();

      // hysteresis sequence 10, 5, 3
      hits(10, 100, 100);
      sof_pulse(0);
      chk("hys1_onRope", int'(onRope), 1);
      ack_cycle();
      hits(5, 100, 100);
      sof_pulse(0);
`ifdef ROPE_GRAB_HYST_EN
      chk("hys2_onRope", int'(onRope), 1);
      chk("hys2_eventReq", int'(eventReq), 0);
`else
      chk("hys2_onRope", int'(onRope), 0);
      chk("hys2_eventType", int'(eventType), 1);
`endif
      ack_cycle();
      hits(3, 100, 100);
      sof_pulse(0);
      chk("hys3_onRope", int'(onRope), 0);
`ifdef ROPE_GRAB_HYST_EN
      chk("hys3_eventReq", int'(eventReq), 1);
      chk("hys3_eventType", int'(eventType), 1);
`else
      chk("hys3_eventReq", int'(eventReq), 0);
`endif

      // new event coinciding with ack: event wins, no overrun
      reset = 1'b1; idle(1); reset = 1'b0;
      sof_pulse(0);
      hits(9, 40, 40);
      sof_pulse(0);
      chk("race_grab", int'(eventReq), 1);
      sof_pulse(1);
      chk("race_eventReq", int'(eventReq), 1);
      chk("race_eventType", int'(eventType), 1);
      chk("race_eventOverrun", int'(eventOverrun), 0);
      ack_cycle();
      chk("race_acked", int'(eventReq), 0);
      ack_cycle();
      chk("stray_ack", int'(eventReq), 0);
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rope_grab_detector.md
Name: rope_grab_detector

Overview:
- Consumer end of the per-pixel drawing-request interface produced by the rope and player display blocks.
- Samples ropeDR and playerDR on every pixel of a frame and accumulates rope/player overlap.
- At each frame boundary, decides whether the player is on a rope, then publishes the result to game logic.
- Raises a held grab/release event under a req/ack handshake; sits between the object display blocks and the game-control FSM.

Parameters:
- OVERLAP_THRESHOLD, 8: minimum overlapping pixels per frame to count as on-rope.
- CNT_W, 12: overlap counter width; the counter saturates.
- SCREEN_W, 640: active width; pixels with pixelX >= SCREEN_W are ignored.
- SCREEN_H, 480: active height; pixels with pixelY >= SCREEN_H are ignored.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse marking a frame boundary
- pixelX  in  11  current pixel column
- pixelY  in  11  current pixel row
- ropeDR  in  1  rope drawing request for the current pixel
- playerDR  in  1  player drawing request for the current pixel
- onRope  out  1  level; on-rope decision for the last completed frame
- overlapCount  out  CNT_W  overlap pixel count of the last completed frame
- grabX  out  11  leftmost overlap column of the last frame; 0 if no overlap
- grabY  out  11  topmost overlap row of the last frame; 0 if no overlap
- eventReq  out  1  event pending; held until acknowledged
- eventType  out  1  0 = GRAB, 1 = RELEASE
- eventOverrun  out  1  sticky; an event was overwritten while pending
- eventAck  in  1  game logic accepts the pending event

Behaviour:
- Reset (clk edge with reset=1): all outputs 0, accumulators cleared, minX/minY = all ones, FSM -> IDLE. Reset dominates every other input on the same edge, including mid-frame.
- FSM states: IDLE, SCAN.
  - IDLE: ignore pixels; on startOfFrame go to SCAN with clear accumulators. No commit from IDLE, so the first partial frame is discarded.
  - SCAN: accumulate; on startOfFrame commit and stay in SCAN.
- Overlap pixel: ropeDR & playerDR & pixelX < SCREEN_W & pixelY < SCREEN_H.
- On each overlap pixel:
  - count increments, saturating at 2^CNT_W-1 with no wrap;
  - minX = min(minX, pixelX);
  - minY = min(minY, pixelY).
- Commit (SCAN & startOfFrame), all outputs registered, visible the cycle after the pulse:
  - overlapCount <= count;
  - onRope <= (count >= OVERLAP_THRESHOLD);
  - grabX/grabY <= minX/minY if count > 0, else 0;
  - accumulators reset;
  - the pixel sampled on the commit cycle counts toward the NEW frame.
- Events are generated on commit only:
  - onRope 0->1 raises GRAB;
  - onRope 1->0 raises RELEASE;
  - no change raises nothing.
- Handshake:
  - eventReq=1 with eventType stable until a cycle where eventAck=1; eventReq clears the next edge.
  - eventAck while eventReq=0 is ignored.
- Simultaneous new event and eventAck on the same edge: the new event wins; eventReq stays 1, eventType is updated, no overrun.
- New event while pending without ack: eventType is overwritten and eventOverrun is set. eventOverrun clears only on reset.
- Back-to-back startOfFrame on consecutive cycles: the second commit publishes the one-cycle frame, which is legal.
- Latency: startOfFrame at edge N produces outputs and eventReq valid after edge N.

Optional Feature:
- Macro ROPE_GRAB_HYST_EN.
- Defined: release hysteresis. While onRope=1, the commit keeps onRope=1 unless count < OVERLAP_THRESHOLD/2 (integer division). The grab condition is unchanged.
- Undefined: a single threshold applies both ways, as specified above.

Decomposition:
- Package rope_grab_pkg holds:
  - state enum {IDLE, SCAN};
  - event enum {EV_GRAB=0, EV_RELEASE=1};
  - pixel coordinate width constant (11).
- Sub-module overlap_accumulator: holds the saturating counter and minX/minY trackers, with inputs clear, hit, pixelX, pixelY.
- The top level keeps the FSM, commit registers and event handshake.

Test Plan:
- Reset mid-frame after 5 overlap pixels, then two frames each with 0 overlaps -> onRope=0, overlapCount=0, grabX=grabY=0, eventReq never set.
- Frame with 10 overlaps at X=200..209, Y=150 -> after startOfFrame: overlapCount=10, onRope=1, grabX=200, grabY=150, eventReq=1, eventType=GRAB; ack 3 cycles later -> eventReq=0 one cycle after ack.
- Next frame with 3 overlaps, no ack -> RELEASE pending. Then a frame with 12 overlaps, still no ack -> eventType=GRAB, eventOverrun=1.
- Overlap pixels with pixelX=640 or pixelY=480 only -> overlapCount=0.
- CNT_W=4, 20 overlaps -> overlapCount=15, no wrap.
- ROPE_GRAB_HYST_EN defined, THRESHOLD=8: frames with counts 10, 5, 3 -> onRope = 1, 1, 0; RELEASE only after the third frame. Without the macro, RELEASE after the second frame.
